// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, NOP encoding and the
// {pc, instr} record that travels from fetch through decode.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: enqueue side from fetch, dequeue side to decode.
interface fetch_queue_if #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
);

  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;

  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;

  // The queue itself.
  modport slave (
    input  enq_valid, enq_pc, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr
  );

  // The pipeline around the queue (fetch drives, decode consumes).
  modport master (
    output enq_valid, enq_pc, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr
  );

endinterface : fetch_queue_if

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port at the tail,
// one asynchronous read port at the head.
module fq_storage #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the control logic, so
  // resetting storage would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : fq_storage

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode/rename, with single-cycle flush on
// redirect. Occupancy is counted explicitly; pointers wrap naturally.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = cpu_pkg::XLEN,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  output logic [CW-1:0]   count,
  fetch_queue_if.slave    bus
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq_fire, deq_fire;
  logic              wr_en;
  logic [2*XLEN-1:0] wr_data;
  logic [2*XLEN-1:0] rd_data;

  assign bus.enq_ready = (count_q != FULL_COUNT);
  assign bus.deq_valid = (count_q != '0);
  assign enq_fire      = bus.enq_valid && bus.enq_ready;
  assign deq_fire      = bus.deq_valid && bus.deq_ready;

  // A handshake coinciding with flush must not leave an entry behind.
  assign wr_en   = enq_fire && !flush;
  assign wr_data = {bus.enq_pc, bus.enq_instr};

  // NOTE: every variable written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PW'(1);
      if (deq_fire) head_d = head_q + PW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_storage (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (tail_q),
    .wr_data_i (wr_data),
    .rd_addr_i (head_q),
    .rd_data_o (rd_data)
  );

  // Zero the outputs when empty so decode never sees stale array contents.
  assign bus.deq_pc    = bus.deq_valid ? rd_data[2*XLEN-1:XLEN] : '0;
  assign bus.deq_instr = bus.deq_valid ? rd_data[XLEN-1:0]      : '0;
  assign count         = count_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: reset, pass-through, full, wrap with
// concurrent enq/deq, flush and asynchronous reset mid-operation.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_queue_if #(.XLEN(XLEN)) bus ();

  fetch_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .count (count),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enq_valid = 1'b0;
    bus.enq_pc    = '0;
    bus.enq_instr = '0;
    bus.deq_ready = 1'b0;
    flush         = 1'b0;
  endtask

  // Enqueue one entry with deq_ready held low.
  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
    bus.enq_valid = 1'b1;
    bus.enq_pc    = pc;
    bus.enq_instr = instr;
    bus.deq_ready = 1'b0;
    tick();
    bus.enq_valid = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return NOP ^ {pc[19:0], 12'h000};
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
    n_checks++;
    if (bus.deq_valid !== 1'b0) $display("FAIL reset_deq_valid: got %b want 0", bus.deq_valid);
    else n_pass++;
    n_checks++;
    if (bus.enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b want 1", bus.enq_ready);
    else n_pass++;
    n_checks++;
    if (bus.deq_pc !== 32'h0) $display("FAIL reset_deq_pc: got %h want 0", bus.deq_pc);
    else n_pass++;
    n_checks++;
    if (bus.deq_instr !== 32'h0) $display("FAIL reset_deq_instr: got %h want 0", bus.deq_instr);
    else n_pass++;
  endtask

  task automatic test_pass_through();
    bus.enq_valid = 1'b1;
    bus.enq_pc    = 32'h0000_0000;
    bus.enq_instr = 32'h0050_0093;
    bus.deq_ready = 1'b1;
    n_checks++;
    if (bus.deq_valid !== 1'b0) $display("FAIL pass_no_bypass: deq_valid got %b want 0", bus.deq_valid);
    else n_pass++;
    tick();
    bus.enq_valid = 1'b0;
    n_checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h0 || bus.deq_instr !== 32'h0050_0093)
      $display("FAIL pass_head: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00500093",
               bus.deq_valid, bus.deq_pc, bus.deq_instr);
    else n_pass++;
    tick();
    bus.deq_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0 || bus.deq_valid !== 1'b0)
      $display("FAIL pass_drained: got count=%0d v=%b want count=0 v=0", count, bus.deq_valid);
    else n_pass++;
  endtask

  task automatic test_fill_full();
    logic [XLEN-1:0] pc;
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'(i * 4);
      push(pc, instr_of(pc));
    end
    n_checks++;
    if (count !== 4'd8 || bus.enq_ready !== 1'b0)
      $display("FAIL full_state: got count=%0d enq_ready=%b want 8/0", count, bus.enq_ready);
    else n_pass++;
    push(32'h20, instr_of(32'h20));
    n_checks++;
    if (count !== 4'd8) $display("FAIL full_reject: count got %0d want 8", count);
    else n_pass++;
    // Holding deq_ready=0 must keep the head stable.
    tick();
    n_checks++;
    if (bus.deq_pc !== 32'h0 || bus.deq_instr !== instr_of(32'h0))
      $display("FAIL full_stall_stable: got pc=%h instr=%h want pc=0", bus.deq_pc, bus.deq_instr);
    else n_pass++;
    bus.deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'(i * 4);
      n_checks++;
      if (bus.deq_valid !== 1'b1 || bus.deq_pc !== pc || bus.deq_instr !== instr_of(pc))
        $display("FAIL drain_order[%0d]: got v=%b pc=%h instr=%h want pc=%h instr=%h",
                 i, bus.deq_valid, bus.deq_pc, bus.deq_instr, pc, instr_of(pc));
      else n_pass++;
      tick();
    end
    bus.deq_ready = 1'b0;
    n_checks++;
    if (bus.deq_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL drain_empty: got v=%b count=%0d want 0/0 (pc 0x20 must not appear)",
               bus.deq_valid, count);
    else n_pass++;
  endtask

  task automatic test_wrap_simultaneous();
    logic [XLEN-1:0] exp_pc;
    int              bad;
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(4 * i), instr_of(32'h100 + 32'(4 * i)));
    bad = 0;
    bus.deq_ready = 1'b1;
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_pc        = 32'h100 + 32'(4 * i);
      bus.enq_pc    = 32'h100 + 32'(4 * (i + 3));
      bus.enq_instr = instr_of(bus.enq_pc);
      if (count !== 4'd3 || bus.deq_valid !== 1'b1 || bus.deq_pc !== exp_pc
          || bus.deq_instr !== instr_of(exp_pc)) begin
        if (bad == 0)
          $display("FAIL wrap_cycle[%0d]: got count=%0d pc=%h want count=3 pc=%h",
                   i, count, bus.deq_pc, exp_pc);
        bad++;
      end
      tick();
    end
    bus.enq_valid = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL wrap_steady: %0d bad cycles, want 0", bad);
    else n_pass++;
    for (int i = 20; i < 23; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      n_checks++;
      if (bus.deq_pc !== exp_pc) $display("FAIL wrap_tail[%0d]: got pc=%h want %h", i, bus.deq_pc, exp_pc);
      else n_pass++;
      tick();
    end
    bus.deq_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0) $display("FAIL wrap_empty: count got %0d want 0", count);
    else n_pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(4 * i), instr_of(32'h200 + 32'(4 * i)));
    n_checks++;
    if (count !== 4'd5) $display("FAIL flush_preload: count got %0d want 5", count);
    else n_pass++;
    flush         = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_pc    = 32'h40;
    bus.enq_instr = instr_of(32'h40);
    bus.deq_ready = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (count !== 4'd0 || bus.deq_valid !== 1'b0 || bus.deq_pc !== 32'h0)
      $display("FAIL flush_clear: got count=%0d v=%b pc=%h want 0/0/0", count, bus.deq_valid, bus.deq_pc);
    else n_pass++;
    push(32'h80, instr_of(32'h80));
    n_checks++;
    if (count !== 4'd1 || bus.deq_pc !== 32'h80 || bus.deq_instr !== instr_of(32'h80))
      $display("FAIL flush_refill: got count=%0d pc=%h want 1/00000080", count, bus.deq_pc);
    else n_pass++;
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    n_checks++;
    if (bus.deq_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL flush_no_ghost: got v=%b pc=%h want empty", bus.deq_valid, bus.deq_pc);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), instr_of(32'h300 + 32'(4 * i)));
    n_checks++;
    if (count !== 4'd4) $display("FAIL areset_preload: count got %0d want 4", count);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0 || bus.deq_valid !== 1'b0 || bus.enq_ready !== 1'b1 || bus.deq_pc !== 32'h0)
      $display("FAIL areset_immediate: got count=%0d v=%b rdy=%b pc=%h want 0/0/1/0",
               count, bus.deq_valid, bus.enq_ready, bus.deq_pc);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd0 || bus.deq_valid !== 1'b0)
      $display("FAIL areset_after: got count=%0d v=%b want 0/0", count, bus.deq_valid);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_pass_through();
    test_fill_full();
    test_wrap_simultaneous();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the instruction fetch stage (PC + instruction word) and the decode/rename stage of the out-of-order CPU.
- Absorbs fetch/decode rate mismatch and back-pressure from a stalled rename.
- Supports a one-cycle flush on branch mispredict or exception redirect.
- Each entry holds a {pc, instr} pair, dequeued in program order.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- XLEN, 32, width of PC and instruction fields.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all entries; from branch/exception redirect logic.
- enq_valid  input  1  fetch presents a valid instruction.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_pc  input  XLEN  PC of the fetched instruction.
- enq_instr  input  XLEN  fetched instruction word.
- deq_valid  output  1  head entry valid for decode.
- deq_ready  input  1  decode consumes the head entry this cycle.
- deq_pc  output  XLEN  PC of the head entry.
- deq_instr  output  XLEN  instruction word of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: the clock port is clk, the reset port is rst_n, and asserting rst_n low clears state immediately, independent of clk.
- Reset values: head=0, tail=0, count=0, deq_valid=0, deq_pc=0, deq_instr=0, enq_ready=1. Storage contents need not be reset.
- Handshake:
  - Enqueue fires when enq_valid && enq_ready.
  - Dequeue fires when deq_valid && deq_ready.
  - enq_ready = (count != DEPTH). It does not depend on deq_ready: no enqueue into a full queue even if a dequeue fires the same cycle.
  - deq_valid = (count != 0).
- Latency: an entry enqueued at edge N is presented at the deq port after edge N. Minimum fetch-to-decode latency is 1 cycle. There is no combinational enq-to-deq bypass.
- Output data:
  - deq_pc and deq_instr come combinationally from the head entry when deq_valid=1.
  - Both are forced to 0 when deq_valid=0.
  - They are stable while deq_valid=1 and deq_ready=0.
- Pointers:
  - head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is tracked separately.
  - Full/empty are decided by count only.
- Count update per edge:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue. This is legal whenever 0 < count < DEPTH. At count=0 only enqueue can fire; at count=DEPTH only dequeue can fire.
- Flush:
  - Highest priority.
  - On an edge with flush=1: head=0, tail=0, count=0.
  - Any enqueue or dequeue handshake in that cycle is ignored: the entry is not stored, and the head is not considered consumed by the queue.
  - deq_valid=0 from the following cycle.
  - Refill resumes the next cycle.
- Reset mid-operation: all in-flight entries are lost. Outputs take their reset values asynchronously.
- Order: strict FIFO. No reordering and no duplicate outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN.
  - NOP encoding 32'h00000013.
  - fetch_entry_t {pc[XLEN-1:0], instr[XLEN-1:0]}, also reused by fetch and decode.
- One natural sub-module: fq_storage, a DEPTH x (2*XLEN) register array with one write port (tail) and one async read port (head).
- Pointer, count and flush control stay in fetch_queue.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release. Require count=0, deq_valid=0, enq_ready=1, deq_pc=0, deq_instr=0.
- Basic pass-through: enqueue pc=0x00, instr=0x00500093, with deq_ready=1. Next cycle require deq_valid=1, deq_pc=0x00, deq_instr=0x00500093. The cycle after, count=0.
- Fill to full: with deq_ready=0, enqueue 8 entries, pc=0x00..0x1C step 4. Require count=8 and enq_ready=0. A 9th enq_valid is not stored. Then drain with deq_ready=1; require the PCs to appear in order 0x00..0x1C, each exactly once.
- Wrap-around and simultaneous enq/deq: keep count at 3 while continuously enqueuing and dequeuing for 20 cycles, so the pointers wrap twice. Require count stays 3 and the output PC sequence is contiguous.
- Flush: with 5 entries queued, assert flush together with enq_valid (pc=0x40) and deq_ready. Next cycle require count=0 and deq_valid=0. pc=0x40 never appears. A subsequent enqueue of pc=0x80 appears first.
- Async reset mid-operation: with 4 entries queued, drop rst_n between clock edges. Require count=0 and deq_valid=0 immediately, before the next edge.
